// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
//   arb_state_e : two-state arbiter FSM encoding (IDLE / GRANT)
//   SRC_*       : mux source index codes, {sel1,sel2} value per input a..d
//   onehot4     : index -> one-hot grant vector
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the four requesters and the arbiter.
//   req   : per-requester request (bit i wants mux input i)
//   grant : one-hot current owner, zero when idle
//   valid : a grant is active, mux output y is meaningful
//   sel1  : mux select MSB, sel2 : mux select LSB
// master = requester / mux side, slave = arbiter side.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       valid;
    logic       sel1;
    logic       sel2;

    modport master (output req, input grant, valid, sel1, sel2);
    modport slave  (input req, output grant, valid, sel1, sel2);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational cyclic priority picker.
//   req      in  4 : candidate requests
//   ptr      in  2 : highest-priority index; search ptr, ptr+1, .. ptr+3 (mod 4)
//   excl_en  in  1 : when set, excl_idx is never picked
//   excl_idx in  2 : index to skip
//   found    out 1 : some eligible request exists
//   idx      out 2 : first eligible index from ptr (ptr when none found)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       excl_en,
    input  logic [1:0] excl_idx,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Scan from the lowest priority up so the highest-priority hit is the last write.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand] && !(excl_en && (cand == excl_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux between four requesters.
// A grant is held while the owner requests, up to MAX_HOLD cycles when others
// are waiting (MAX_HOLD=0 disables the limit). All outputs are registered:
// req sampled at edge N shows up on grant/sel/valid after edge N.
//   clk   in : clock, rising edge
//   rst   in : synchronous active-high reset
//   bus      : slave side of mux4_rr_arbiter_if (req in; grant/valid/sel1/sel2 out)
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_arbiter_if.slave   bus
);

    localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
    // Without a limit the counter just parks at all-ones instead of wrapping.
    localparam logic [HOLD_W-1:0] HOLD_CAP = TIMEOUT_EN ? HOLD_W'(MAX_HOLD) : '1;

    arb_state_e        state_q, state_d;
    logic [1:0]        ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        sel_q,   sel_d;
    logic              valid_q, valid_d;

    logic [1:0] owner;
    logic [1:0] pick_ptr;
    logic       pick_excl;
    logic       pick_found;
    logic [1:0] pick_idx;

    // sel_q always holds the current owner while in GRANT.
    assign owner = sel_q;

    // In GRANT every handoff searches from owner+1 with the owner last/excluded;
    // on release the owner is not requesting, so excluding it changes nothing.
    assign pick_ptr  = (state_q == ST_GRANT) ? (owner + 2'd1) : ptr_q;
    assign pick_excl = (state_q == ST_GRANT);

    rr_pick4 u_pick (
        .req      (bus.req),
        .ptr      (pick_ptr),
        .excl_en  (pick_excl),
        .excl_idx (owner),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    grant_d = onehot4(pick_idx);
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (!bus.req[owner]) begin
                    // Release wins over timeout.
                    ptr_d = owner + 2'd1;
                    if (pick_found) begin
                        grant_d = onehot4(pick_idx);
                        sel_d   = pick_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (TIMEOUT_EN && (hold_q == HOLD_CAP)) begin
                    hold_d = HOLD_W'(1);
                    if (pick_found) begin
                        ptr_d   = owner + 2'd1;
                        grant_d = onehot4(pick_idx);
                        sel_d   = pick_idx;
                    end
                end else if (hold_q != HOLD_CAP) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
            grant_q <= 4'b0000;
            sel_q   <= SRC_A;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.valid = valid_q;
    assign bus.sel1  = sel_q[1];
    assign bus.sel2  = sel_q[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'b0000;   // mux inputs {d,c,b,a}
    logic       y;

    int checks   = 0;
    int failures = 0;

    // Reference model state, plain integers; owner = -1 means idle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_last  = 0;

    mux4_rr_arbiter_if ar_if ();

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ar_if.slave)
    );

    // The shared 4:1 mux, driven by the arbiter's select lines.
    assign y = din[{ar_if.sel1, ar_if.sel2}];

    always #5 clk = ~clk;

    function automatic int first_req(input logic [3:0] r, input int p, input int ex);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (i != ex && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input bit rs);
        int w;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0;
        end else if (m_owner < 0) begin
            w = first_req(r, m_ptr, -1);
            if (w >= 0) begin m_owner = w; m_last = w; m_hold = 1; end
        end else if (!r[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            w = first_req(r, m_ptr, -1);
            if (w >= 0) begin m_owner = w; m_last = w; m_hold = 1; end
            else m_owner = -1;
        end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
            w = first_req(r, (m_owner + 1) % 4, m_owner);
            if (w >= 0) begin
                m_ptr = (m_owner + 1) % 4;
                m_owner = w; m_last = w;
            end
            m_hold = 1;
        end else begin
            m_hold = m_hold + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("grant", 32'(ar_if.grant), 32'(eg));
        chk("valid", 32'(ar_if.valid), 32'(m_owner >= 0));
        chk("sel",   32'({ar_if.sel1, ar_if.sel2}), 32'(m_last));
        if (m_owner >= 0) chk("mux_y", 32'(y), 32'(din[m_owner]));
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge.
    task automatic cycle(input logic [3:0] r, input bit rs);
        ar_if.req = r;
        rst       = rs;
        din       = 4'($urandom);
        @(posedge clk);
        model_step(r, rs);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [3:0] r;
        int         exp_seq [5];
        ar_if.req = 4'b1111;

        // Reset held two cycles with everybody requesting.
        for (int i = 0; i < 2; i++) begin
            cycle(4'b1111, 1'b1);
            chk("rst_grant", 32'(ar_if.grant), 32'h0);
            chk("rst_valid", 32'(ar_if.valid), 32'h0);
            chk("rst_sel", 32'({ar_if.sel1, ar_if.sel2}), 32'h0);
        end

        // Single requester c, then drop: sel must stay at c.
        cycle(4'b0100, 1'b0);
        chk("single_grant", 32'(ar_if.grant), 32'h4);
        chk("single_sel", 32'({ar_if.sel1, ar_if.sel2}), 32'h2);
        cycle(4'b0000, 1'b0);
        chk("drop_valid", 32'(ar_if.valid), 32'h0);
        chk("drop_sel", 32'({ar_if.sel1, ar_if.sel2}), 32'h2);

        // Rotation: each owner holds two cycles then drops for one edge.
        cycle(4'b0000, 1'b1);
        exp_seq = '{0, 1, 2, 3, 0};
        cycle(4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("rot_owner", 32'(ar_if.grant), 32'(1 << exp_seq[k]));
            cycle(4'b1111, 1'b0);
            chk("rot_hold", 32'(ar_if.grant), 32'(1 << exp_seq[k]));
            r = 4'b1111;
            r[exp_seq[k]] = 1'b0;
            cycle(r, 1'b0);
            chk("rot_nobubble", 32'(ar_if.valid), 32'h1);
        end

        // Timeout alternation between a and b.
        cycle(4'b0000, 1'b1);
        for (int t = 1; t <= 40; t++) begin
            cycle(4'b0011, 1'b0);
            chk("timeout_owner", 32'(ar_if.grant), 32'(1 << (((t - 1) / MAX_HOLD) % 2)));
        end

        // Lone requester keeps the grant past the limit.
        cycle(4'b0000, 1'b1);
        for (int t = 0; t < 20; t++) cycle(4'b0001, 1'b0);
        chk("lone_keep", 32'(ar_if.grant), 32'h1);

        // Mid-grant reset puts ptr back to 0.
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b0);
        chk("mid_pre", 32'(ar_if.grant), 32'h4);
        cycle(4'b0100, 1'b1);
        chk("mid_rst_grant", 32'(ar_if.grant), 32'h0);
        chk("mid_rst_sel", 32'({ar_if.sel1, ar_if.sel2}), 32'h0);
        cycle(4'b1100, 1'b0);
        chk("mid_after", 32'(ar_if.grant), 32'h4);

        // Randomized traffic against the model; sticky requests exercise timeouts.
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] = 1'b0;
            cycle(r, $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
